// File: rtl/zstd_pkg.sv
// Shared types and constants for the Zstandard frame sequencer and its helpers.
package zstd_pkg;

  typedef enum logic [1:0] {
    BlkRaw        = 2'd0,
    BlkRle        = 2'd1,
    BlkCompressed = 2'd2,
    BlkReserved   = 2'd3
  } blk_type_e;

  localparam logic [1:0] OwnerSeq = 2'd0;
  localparam logic [1:0] OwnerHdr = 2'd1;
  localparam logic [1:0] OwnerBlk = 2'd2;

  localparam logic [2:0] ErrNone         = 3'd0;
  localparam logic [2:0] ErrReservedType = 3'd1;
  localparam logic [2:0] ErrBlockSize    = 3'd2;
  localparam logic [2:0] ErrProtocol     = 3'd3;

  localparam int unsigned MaxBlockSizeDefault = 131072;

  // Block header field positions within the 24-bit little-endian header
  localparam int unsigned BhLastBit = 0;
  localparam int unsigned BhTypeLsb = 1;
  localparam int unsigned BhSizeLsb = 3;
  localparam int unsigned BhSizeW   = 21;

  localparam int unsigned DescChecksumBit = 2;

endpackage

// File: rtl/zstd_byte_gatherer.sv
// Collects 3 or 4 little-endian bytes from an optional leftover byte plus 16-bit words,
// reporting the value, completion and any byte left over from the final word.
module zstd_byte_gatherer (
  input  logic        clk,
  input  logic        reset,
  input  logic        active_i,
  input  logic        need4_i,
  input  logic        carry_valid_i,
  input  logic [7:0]  carry_byte_i,
  input  logic [15:0] word_i,
  input  logic        word_fire_i,
  output logic        done_o,
  output logic [31:0] value_o,
  output logic        carry_valid_o,
  output logic [7:0]  carry_byte_o
);

  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic        primed_q, primed_d;
  logic [2:0]  need, base_cnt, total;
  logic [31:0] base_acc;

  always_comb begin
    need = need4_i ? 3'd4 : 3'd3;
    // The incoming carry counts as the first byte until the first word lands
    if (primed_q) begin
      base_cnt = cnt_q;
      base_acc = acc_q;
    end else begin
      base_cnt = {2'b00, carry_valid_i};
      base_acc = carry_valid_i ? {24'h0, carry_byte_i} : 32'h0;
    end
    total   = base_cnt + 3'd2;
    value_o = base_acc;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) == base_cnt && 3'(i) < need) value_o[i*8 +: 8] = word_i[15:8];
      if (3'(i) == base_cnt + 3'd1 && 3'(i) < need) value_o[i*8 +: 8] = word_i[7:0];
    end
    done_o        = active_i & word_fire_i & (total >= need);
    carry_valid_o = total > need;
    carry_byte_o  = word_i[7:0];

    cnt_d    = cnt_q;
    acc_d    = acc_q;
    primed_d = primed_q;
    if (!active_i || done_o) begin
      cnt_d    = 3'd0;
      acc_d    = 32'h0;
      primed_d = 1'b0;
    end else if (word_fire_i) begin
      cnt_d    = total;
      acc_d    = value_o;
      primed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 3'd0;
      acc_q    <= 32'h0;
      primed_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      primed_q <= primed_d;
    end
  end

endmodule

// File: rtl/zstd_frame_sequencer.sv
// Frame-level controller: walks header, block headers, block payloads and checksum,
// arbitrating the shared input bus and carrying odd leftover bytes between phases.
module zstd_frame_sequencer
  import zstd_pkg::*;
#(
  parameter int unsigned MAX_BLOCK_SIZE = MaxBlockSizeDefault,
  parameter int unsigned COUNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [1:0]         owner,
  output logic               hdr_start,
  input  logic               hdr_finished,
  input  logic [7:0]         hdr_descriptor,
  input  logic               hdr_tail_valid,
  input  logic [7:0]         hdr_tail_byte,
  output logic               blk_start,
  output logic [1:0]         blk_type,
  output logic [20:0]        blk_size,
  output logic               blk_last,
  output logic               carry_valid,
  output logic [7:0]         carry_byte,
  input  logic               blk_done,
  input  logic               blk_tail_valid,
  input  logic [7:0]         blk_tail_byte,
  output logic [31:0]        checksum,
  output logic               checksum_valid,
  output logic [COUNT_W-1:0] block_count,
  output logic               frame_done,
  output logic               error,
  output logic [2:0]         error_code
);

  typedef enum logic [2:0] {
    StIdle, StHeader, StBlkHdr, StBlock, StChecksum, StDone, StError
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic               hdr_start_q, hdr_start_d;
  logic               blk_start_q, blk_start_d;
  logic [1:0]         blk_type_q, blk_type_d;
  logic [20:0]        blk_size_q, blk_size_d;
  logic               blk_last_q, blk_last_d;
  logic               carry_valid_q, carry_valid_d;
  logic [7:0]         carry_byte_q, carry_byte_d;
  logic [31:0]        checksum_q, checksum_d;
  logic               checksum_valid_q, checksum_valid_d;
  logic [COUNT_W-1:0] block_count_q, block_count_d;
  logic               frame_done_q, frame_done_d;
  logic               error_q, error_d;
  logic [2:0]         error_code_q, error_code_d;
  logic               ck_flag_q, ck_flag_d;

  logic        gather_active, g_done, g_carry_valid;
  logic [31:0] g_value;
  logic [7:0]  g_carry_byte;
  blk_type_e   hdr_type;
  logic [20:0] hdr_size;
  logic        raise;
  logic [2:0]  raise_code;
  logic        unused_desc_bits;

  assign unused_desc_bits = ^{hdr_descriptor[7:3], hdr_descriptor[1:0]};

  assign gather_active = (state_q == StBlkHdr) || (state_q == StChecksum);
  assign in_ready      = gather_active;

  zstd_byte_gatherer u_gatherer (
    .clk           (clk),
    .reset         (reset),
    .active_i      (gather_active),
    .need4_i       (state_q == StChecksum),
    .carry_valid_i (carry_valid_q),
    .carry_byte_i  (carry_byte_q),
    .word_i        (in_data),
    .word_fire_i   (in_valid & in_ready),
    .done_o        (g_done),
    .value_o       (g_value),
    .carry_valid_o (g_carry_valid),
    .carry_byte_o  (g_carry_byte)
  );

  assign hdr_type = blk_type_e'(g_value[BhTypeLsb +: 2]);
  assign hdr_size = g_value[BhSizeLsb +: BhSizeW];

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    hdr_start_d      = 1'b0;
    blk_start_d      = 1'b0;
    frame_done_d     = 1'b0;
    blk_type_d       = blk_type_q;
    blk_size_d       = blk_size_q;
    blk_last_d       = blk_last_q;
    carry_valid_d    = carry_valid_q;
    carry_byte_d     = carry_byte_q;
    checksum_d       = checksum_q;
    checksum_valid_d = checksum_valid_q;
    block_count_d    = block_count_q;
    error_d          = error_q;
    error_code_d     = error_code_q;
    ck_flag_d        = ck_flag_q;
    raise            = 1'b0;
    raise_code       = ErrNone;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          hdr_start_d      = 1'b1;
          owner_d          = OwnerHdr;
          carry_valid_d    = 1'b0;
          block_count_d    = '0;
          error_d          = 1'b0;
          error_code_d     = ErrNone;
          checksum_valid_d = 1'b0;
          state_d          = StHeader;
        end
      end
      StHeader: begin
        if (hdr_finished) begin
          ck_flag_d     = hdr_descriptor[DescChecksumBit];
          carry_valid_d = hdr_tail_valid;
          carry_byte_d  = hdr_tail_byte;
          owner_d       = OwnerSeq;
          state_d       = StBlkHdr;
        end
      end
      StBlkHdr: begin
        if (g_done) begin
          carry_valid_d = g_carry_valid;
          carry_byte_d  = g_carry_byte;
          if (hdr_type == BlkReserved) begin
            raise      = 1'b1;
            raise_code = ErrReservedType;
          end else if (hdr_size > 21'(MAX_BLOCK_SIZE)) begin
            raise      = 1'b1;
            raise_code = ErrBlockSize;
          end else begin
            blk_type_d  = hdr_type;
            blk_size_d  = hdr_size;
            blk_last_d  = g_value[BhLastBit];
            blk_start_d = 1'b1;
            owner_d     = OwnerBlk;
            state_d     = StBlock;
            if (block_count_q != '1) block_count_d = block_count_q + COUNT_W'(1);
          end
        end
      end
      StBlock: begin
        if (blk_done) begin
          carry_valid_d = blk_tail_valid;
          carry_byte_d  = blk_tail_byte;
          owner_d       = OwnerSeq;
          if (!blk_last_q) begin
            state_d = StBlkHdr;
          end else if (ck_flag_q) begin
            state_d = StChecksum;
          end else begin
            frame_done_d = 1'b1;
            state_d      = StDone;
          end
        end
      end
      StChecksum: begin
        if (g_done) begin
          checksum_d       = g_value;
          checksum_valid_d = 1'b1;
          carry_valid_d    = g_carry_valid;
          carry_byte_d     = g_carry_byte;
          frame_done_d     = 1'b1;
          state_d          = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // A decoder completion can only be legitimate while a block is in flight
    if (blk_done && state_q != StBlock && state_q != StError) begin
      raise      = 1'b1;
      raise_code = ErrProtocol;
    end

    if (raise) begin
      state_d      = StError;
      error_d      = 1'b1;
      error_code_d = raise_code;
      owner_d      = OwnerSeq;
      hdr_start_d  = 1'b0;
      blk_start_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      owner_q          <= OwnerSeq;
      hdr_start_q      <= 1'b0;
      blk_start_q      <= 1'b0;
      blk_type_q       <= 2'd0;
      blk_size_q       <= 21'd0;
      blk_last_q       <= 1'b0;
      carry_valid_q    <= 1'b0;
      carry_byte_q     <= 8'h0;
      checksum_q       <= 32'h0;
      checksum_valid_q <= 1'b0;
      block_count_q    <= '0;
      frame_done_q     <= 1'b0;
      error_q          <= 1'b0;
      error_code_q     <= ErrNone;
      ck_flag_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      hdr_start_q      <= hdr_start_d;
      blk_start_q      <= blk_start_d;
      blk_type_q       <= blk_type_d;
      blk_size_q       <= blk_size_d;
      blk_last_q       <= blk_last_d;
      carry_valid_q    <= carry_valid_d;
      carry_byte_q     <= carry_byte_d;
      checksum_q       <= checksum_d;
      checksum_valid_q <= checksum_valid_d;
      block_count_q    <= block_count_d;
      frame_done_q     <= frame_done_d;
      error_q          <= error_d;
      error_code_q     <= error_code_d;
      ck_flag_q        <= ck_flag_d;
    end
  end

  assign owner          = owner_q;
  assign hdr_start      = hdr_start_q;
  assign blk_start      = blk_start_q;
  assign blk_type       = blk_type_q;
  assign blk_size       = blk_size_q;
  assign blk_last       = blk_last_q;
  assign carry_valid    = carry_valid_q;
  assign carry_byte     = carry_byte_q;
  assign checksum       = checksum_q;
  assign checksum_valid = checksum_valid_q;
  assign block_count    = block_count_q;
  assign frame_done     = frame_done_q;
  assign error          = error_q;
  assign error_code     = error_code_q;

endmodule
